// File: rtl/wt_cache_ctrl_if.sv
// Core/memory-side bundle for the write-through cache controller.
// slave = cache side, master = core plus main-memory side.
interface wt_cache_ctrl_if #(
  parameter int ADDR_W   = 10,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
);
  logic                           MemRead;
  logic                           MemWrite;
  logic [ADDR_W-1:0]              Addr;
  logic [DATA_W-1:0]              WData;
  logic [DATA_W-1:0]              RData;
  logic                           Stall;
  logic                           MmRdReq;
  logic                           MmWrReq;
  logic [ADDR_W-1:0]              MmAddr;
  logic [DATA_W-1:0]              MmWData;
  logic [(DATA_W<<OFFSET_W)-1:0]  MmRBlock;
  logic                           MmReady;
  logic [15:0]                    HitCount;
  logic [15:0]                    MissCount;

  modport slave (
    input  MemRead, MemWrite, Addr, WData,
    input  MmRBlock, MmReady,
    output RData, Stall, MmRdReq, MmWrReq,
    output MmAddr, MmWData, HitCount, MissCount
  );

  modport master (
    output MemRead, MemWrite, Addr, WData,
    output MmRBlock, MmReady,
    input  RData, Stall, MmRdReq, MmWrReq,
    input  MmAddr, MmWData, HitCount, MissCount
  );
endinterface

// File: rtl/wt_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module wt_cache_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic CLK,
  input  logic RST,
  wt_cache_ctrl_if.slave bus
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_MEM  = 2'd2
  } state_t;

  state_t state;

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic [ADDR_W-1:0]   blk_addr;

  assign tag = bus.Addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign idx = bus.Addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign off = bus.Addr[OFFSET_W-1:0];
  assign blk_addr = {bus.Addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES][WORDS];

  logic hit;
  logic refill_done;
  logic wr_done;

  assign hit = valid[idx] && (tag_arr[idx] == tag);
  assign refill_done = (state == RD_MISS) && bus.MmReady;
  assign wr_done = (state == WR_MEM) && bus.MmReady;

  // Core and memory strobes; all forced low while reset is held.
  always_comb begin
    bus.RData   = '0;
    bus.Stall   = 1'b0;
    bus.MmRdReq = 1'b0;
    bus.MmWrReq = 1'b0;
    bus.MmAddr  = '0;
    bus.MmWData = '0;
    if (!RST) begin
      unique case (state)
        IDLE: begin
          if (bus.MemWrite) begin
            bus.Stall   = 1'b1;
            bus.MmWrReq = 1'b1;
            bus.MmAddr  = bus.Addr;
            bus.MmWData = bus.WData;
          end else if (bus.MemRead) begin
            if (hit) begin
              bus.RData = data_arr[idx][off];
            end else begin
              bus.Stall   = 1'b1;
              bus.MmRdReq = 1'b1;
              bus.MmAddr  = blk_addr;
            end
          end
        end
        RD_MISS: begin
          bus.Stall   = 1'b1;
          bus.MmRdReq = 1'b1;
          bus.MmAddr  = blk_addr;
        end
        WR_MEM: begin
          bus.Stall   = ~bus.MmReady;
          bus.MmWrReq = 1'b1;
          bus.MmAddr  = bus.Addr;
          bus.MmWData = bus.WData;
        end
        default: begin
          bus.Stall = 1'b0;
        end
      endcase
    end
  end

  // Controller state and line valid bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.MemWrite) begin
            state <= WR_MEM;
          end else if (bus.MemRead && !hit) begin
            state <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (bus.MmReady) begin
            valid[idx] <= 1'b1;
            state      <= IDLE;
          end
        end
        WR_MEM: begin
          if (bus.MmReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage: block refill, or write-through update on a hit.
  always_ff @(posedge CLK) begin
    if (refill_done) begin
      tag_arr[idx] <= tag;
      for (int w = 0; w < WORDS; w++) begin
        data_arr[idx][w[OFFSET_W-1:0]] <=
          bus.MmRBlock[w*DATA_W +: DATA_W];
      end
    end else if (wr_done && hit) begin
      data_arr[idx][off] <= bus.WData;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic        after_refill;
  logic        rd_hit;
  logic        rd_miss;

  assign rd_hit  = (state == IDLE) && !bus.MemWrite &&
                   bus.MemRead && hit;
  assign rd_miss = (state == IDLE) && !bus.MemWrite &&
                   bus.MemRead && !hit;

  // Saturating counters; the hit right after a refill is the miss itself.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      after_refill <= 1'b0;
    end else begin
      after_refill <= refill_done;
      if (rd_miss && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
      if (rd_hit && !after_refill && hit_cnt != 16'hFFFF) begin
        hit_cnt <= hit_cnt + 16'd1;
      end
    end
  end

  assign bus.HitCount  = hit_cnt;
  assign bus.MissCount = miss_cnt;
`else
  assign bus.HitCount  = '0;
  assign bus.MissCount = '0;
`endif

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// Directed bench for wt_cache_ctrl with a fixed-latency memory model.
// Counter checks follow CACHE_STATS_EN.
module tb_wt_cache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   mcnt = 0;

  always #5 clk = ~clk;

  wt_cache_ctrl_if bus ();

  wt_cache_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Memory: MmReady pulses in the third cycle after a request starts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt        <= 0;
      bus.MmReady <= 1'b0;
    end else if (bus.MmReady) begin
      mcnt        <= 0;
      bus.MmReady <= 1'b0;
    end else if (bus.MmRdReq || bus.MmWrReq) begin
      if (mcnt == 2) begin
        mcnt        <= 0;
        bus.MmReady <= 1'b1;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr,
                       input logic [9:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.Addr     = a;
    bus.WData    = d;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.MmReady && n < 20);
    chk(tag, n, 3);
  endtask

  initial begin
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    bus.Addr     = 10'h010;
    bus.WData    = '0;
    bus.MmRBlock = {32'h44, 32'h33, 32'h22, 32'h11};

    // reset: outputs low even with a read pending
    repeat (2) @(negedge clk);
    chk("rst_stall", bus.Stall, 0);
    chk("rst_rdreq", bus.MmRdReq, 0);
    chk("rst_wrreq", bus.MmWrReq, 0);
    chk("rst_rdata", bus.RData, 0);
    chk("rst_mmaddr", bus.MmAddr, 0);
    chk("rst_hits", bus.HitCount, 0);
    chk("rst_miss", bus.MissCount, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: cold read miss and refill
    @(negedge clk);
    chk("t1_stall", bus.Stall, 1);
    chk("t1_rdreq", bus.MmRdReq, 1);
    chk("t1_mmaddr", bus.MmAddr, 10'h010);
    chk("t1_rdata0", bus.RData, 0);
    wait_ready("t1_lat");
    chk("t1_stall_rdy", bus.Stall, 1);
    @(negedge clk);
    chk("t1_stall_hit", bus.Stall, 0);
    chk("t1_rdata", bus.RData, 32'h11);
    chk("t1_rdreq_hit", bus.MmRdReq, 0);

    // 2: same-cycle hit
    drive(1, 0, 10'h012, 0);
    @(negedge clk);
    chk("t2_stall", bus.Stall, 0);
    chk("t2_rdata", bus.RData, 32'h33);
    chk("t2_rdreq", bus.MmRdReq, 0);

    // 3: write hit goes through and updates the line
    drive(0, 1, 10'h011, 32'hDEADBEEF);
    @(negedge clk);
    chk("t3_stall", bus.Stall, 1);
    chk("t3_wrreq", bus.MmWrReq, 1);
    chk("t3_mmaddr", bus.MmAddr, 10'h011);
    chk("t3_wdata", bus.MmWData, 32'hDEADBEEF);
    wait_ready("t3_lat");
    chk("t3_stall_rdy", bus.Stall, 0);
    chk("t3_wrreq_rdy", bus.MmWrReq, 1);
    drive(1, 0, 10'h011, 0);
    @(negedge clk);
    chk("t3_rd_stall", bus.Stall, 0);
    chk("t3_rd_data", bus.RData, 32'hDEADBEEF);

    // 4: write miss with MemRead also high; write wins, no allocate
    drive(1, 1, 10'h230, 32'h12345678);
    @(negedge clk);
    chk("t4_wrreq", bus.MmWrReq, 1);
    chk("t4_rdreq", bus.MmRdReq, 0);
    chk("t4_mmaddr", bus.MmAddr, 10'h230);
    chk("t4_rdata", bus.RData, 0);
    wait_ready("t4_lat");
    bus.MmRBlock = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    drive(1, 0, 10'h230, 0);
    @(negedge clk);
    chk("t4_rd_stall", bus.Stall, 1);
    chk("t4_rd_rdreq", bus.MmRdReq, 1);
    wait_ready("t4_rd_lat");
    @(negedge clk);
    chk("t4_rd_data", bus.RData, 32'hA0);

    // 5: conflict eviction on index 4
    bus.MmRBlock = {32'h94, 32'h93, 32'h92, 32'h91};
    drive(1, 0, 10'h090, 0);
    @(negedge clk);
    chk("t5a_stall", bus.Stall, 1);
    chk("t5a_mmaddr", bus.MmAddr, 10'h090);
    wait_ready("t5a_lat");
    @(negedge clk);
    chk("t5a_data", bus.RData, 32'h91);
    bus.MmRBlock = {32'h44, 32'h33, 32'hDEADBEEF, 32'h11};
    drive(1, 0, 10'h010, 0);
    @(negedge clk);
    chk("t5b_stall", bus.Stall, 1);
    chk("t5b_rdreq", bus.MmRdReq, 1);
    wait_ready("t5b_lat");
    @(negedge clk);
    chk("t5b_data", bus.RData, 32'h11);
    drive(1, 0, 10'h011, 0);
    @(negedge clk);
    chk("t5c_data", bus.RData, 32'hDEADBEEF);
    drive(0, 0, 10'h011, 0);
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("t5_hits", bus.HitCount, 3);
    chk("t5_miss", bus.MissCount, 4);
    drive(1, 0, 10'h012, 0);
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("t5_hit_sat", bus.HitCount, 16'hFFFF);
    chk("t5_miss_hold", bus.MissCount, 4);
`else
    chk("t5_hits_off", bus.HitCount, 0);
    chk("t5_miss_off", bus.MissCount, 0);
`endif

    // 6: reset in the middle of a refill
    bus.MmRBlock = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    drive(1, 0, 10'h0F0, 0);
    @(negedge clk);
    chk("t6_stall", bus.Stall, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", bus.Stall, 0);
    chk("t6_rst_rdreq", bus.MmRdReq, 0);
    chk("t6_rst_miss", bus.MissCount, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_re_stall", bus.Stall, 1);
    chk("t6_re_rdreq", bus.MmRdReq, 1);
    wait_ready("t6_lat");
    @(negedge clk);
    chk("t6_data", bus.RData, 32'hF0);
    drive(1, 0, 10'h010, 0);
    @(negedge clk);
    chk("t6_old_miss", bus.Stall, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wt_cache_ctrl.md
Name: wt_cache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data cache with its controller. It sits between the core's data-memory port and main memory, and is the responder to the MemRead/MemWrite strobes produced by the core's control unit. It serves read hits in zero wait cycles. It stalls the core through read-miss refills and through every write while the write propagates to main memory.

Parameters:
ADDR_W, 10, word-address width from the core
INDEX_W, 5, index bits (32 lines)
OFFSET_W, 2, word-in-block bits (4 words per block)
DATA_W, 32, word width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
MemRead  input  1  core read strobe
MemWrite  input  1  core write strobe
Addr  input  ADDR_W  core word address
WData  input  DATA_W  core write data
RData  output  DATA_W  read data to core
Stall  output  1  core must hold PC, pipeline and its inputs
MmRdReq  output  1  main-memory block read request
MmWrReq  output  1  main-memory word write request
MmAddr  output  ADDR_W  memory address; block-aligned (offset bits zero) for reads
MmWData  output  DATA_W  memory write data
MmRBlock  input  DATA_W<<OFFSET_W  refill block; word 0 in the LSBs
MmReady  input  1  memory completed the current request (one-cycle pulse)
HitCount  output  16  read-hit counter (optional feature)
MissCount  output  16  read-miss counter (optional feature)

Behaviour:
- Address fields: tag = Addr[ADDR_W-1:INDEX_W+OFFSET_W], index = Addr[INDEX_W+OFFSET_W-1:OFFSET_W], offset = Addr[OFFSET_W-1:0].
- Storage: valid, tag and data arrays are registers. Hit = valid[index] AND tag match, evaluated combinationally.
- FSM states: IDLE, RD_MISS, WR_MEM.
- IDLE:
  - MemWrite = 1 → Stall = 1, MmWrReq = 1, MmAddr = Addr, MmWData = WData; next state WR_MEM.
  - Else MemRead = 1 with a hit → Stall = 0, RData = selected word in the same cycle.
  - Else MemRead = 1 with a miss → Stall = 1, MmRdReq = 1, block-aligned MmAddr; next state RD_MISS.
  - MmReady is ignored in IDLE.
- RD_MISS:
  - Hold MmRdReq, MmAddr and Stall = 1.
  - On a cycle with MmReady = 1: write MmRBlock into the line, set valid and tag; next state IDLE.
  - The following IDLE cycle hits, so a read miss costs memory latency + 1 cycle.
- WR_MEM:
  - Hold MmWrReq, MmAddr and MmWData; Stall = ~MmReady.
  - On a cycle with MmReady = 1: if hit, update the cached word (a miss does not allocate); next state IDLE. The core advances on that same edge.
- MemRead and MemWrite both high: MemWrite wins.
- The core holds MemRead, MemWrite, Addr and WData stable while Stall = 1.
- RData is 0 whenever there is no read hit. Stall, MmRdReq and MmWrReq are combinational from state and inputs.
- Reset values: state IDLE, all valid bits 0, all outputs 0, counters 0.
- Reset asserted mid-operation: the request is dropped immediately and any in-flight refill is discarded.

Optional Feature:
CACHE_STATS_EN:
- Defined: HitCount and MissCount are 16-bit, saturating at 0xFFFF.
  - MissCount increments on each IDLE→RD_MISS transition.
  - HitCount increments on each IDLE read-hit cycle, except the hit that immediately follows a refill.
  - Writes are not counted.
- Undefined: both outputs are tied to 0 and no counter logic is built. The ports remain for interface stability.

Test Plan:
All scenarios use a memory model that pulses MmReady 3 cycles after a request.
1. After reset, read 0x010 → Stall = 1, MmRdReq = 1, MmAddr = 0x010. Model returns block {0x44,0x33,0x22,0x11}. The cycle after MmReady: Stall = 0, RData = 0x11.
2. Then read 0x012 → same-cycle hit, Stall = 0, RData = 0x33, MmRdReq stays 0.
3. Write 0x011 = 0xDEADBEEF (hit) → MmWrReq = 1, MmAddr = 0x011, MmWData = 0xDEADBEEF. Stall falls in the MmReady cycle. A later read of 0x011 hits with 0xDEADBEEF.
4. Write miss to 0x230 → memory write issued. A later read of 0x230 misses, proving no allocate.
5. Read 0x090 (index 4, same index as 0x010, different tag) → miss and eviction. Read 0x010 → miss again. With CACHE_STATS_EN, the counters match the hand-computed values, and saturation at 0xFFFF holds under a forced long hit loop.
6. Assert RST during RD_MISS → Stall and MmRdReq drop immediately. A read of the same address after reset misses.
